// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, capture FSM states and the pattern decoder
// shared by the signed 7-segment capture path.
package seg7_pkg;
    localparam int SIGN_BIT = 7;
    // Indexed by the 4-bit two's-complement value, so index 8 is -8 and index 15 is -1.
    localparam logic [7:0] SEG_CODE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'hFF, 8'h87, 8'hFD, 8'hED, 8'hE6, 8'hCF, 8'hDB, 8'h86
    };
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    // The sign segment selects the half of the table to search; returns {err, val}.
    function automatic logic [4:0] decode(input logic [7:0] p);
        logic [3:0] v;
        decode = 5'h10;
        for (int i = 0; i < 8; i++) begin
            v = {p[SIGN_BIT], 3'(i)};
            if (p == SEG_CODE[v]) decode = {1'b0, v};
        end
    endfunction
endpackage

// File: rtl/seg_capture_decoder_if.sv
// seg_capture_decoder_if: multiplexed segment/digit bus plus the decoded
// result valid/ready channel.
interface seg_capture_decoder_if #(parameter int DIGITS = 4);
    logic [7:0]        seg_n;
    logic [DIGITS-1:0] dig_n;
    logic [3:0]        out_val;
    logic [2:0]        out_dig;
    logic              out_err;
    logic              out_valid;
    logic              out_ready;
    logic              overflow;
    modport master (output seg_n, dig_n, out_ready,
                    input  out_val, out_dig, out_err, out_valid, overflow);
    modport slave  (input  seg_n, dig_n, out_ready,
                    output out_val, out_dig, out_err, out_valid, overflow);
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with asynchronous active-low reset to RST_VAL.
module sync2 #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] m;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m <= RST_VAL;
            q <= RST_VAL;
        end else begin
            m <= d;
            q <= m;
        end
endmodule

// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder: waits for a multiplexed digit pattern to settle, decodes
// it to a signed value and offers it through a one-deep valid/ready buffer.
module seg_capture_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    seg_capture_decoder_if.slave bus
);
    logic [7:0]        seg_s;
    logic [DIGITS-1:0] dig_s;
    logic [7:0]        p;
    logic [2:0]        dig;
    logic              idle;
    logic              same;
    logic              cap;
    logic [4:0]        dec;
    state_t            state, state_nx;
    logic [7:0]        cnt, cnt_nx;
    logic [7:0]        ref_p, ref_p_nx;
    logic [2:0]        ref_dig, ref_dig_nx;
    logic [3:0]        val_q;
    logic [2:0]        dig_q;
    logic              err_q, valid_q, ovf_q;

    sync2 #(.W(8 + DIGITS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bus.seg_n, bus.dig_n}),
        .q     ({seg_s, dig_s})
    );

    assign p    = ~seg_s;
    assign idle = (p == '0) || !$onehot(~dig_s);
    assign same = (p == ref_p) && (dig == ref_dig);
    assign dec  = decode(p);

    always_comb begin
        dig = '0;
        for (int i = 0; i < DIGITS; i++)
            if (!dig_s[i]) dig = 3'(i);
    end

    // A differing non-idle sample always restarts settling, from either SETTLE or HOLD.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ref_p_nx   = ref_p;
        ref_dig_nx = ref_dig;
        cap        = 1'b0;
        if (idle) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == IDLE || !same) begin
            state_nx   = SETTLE;
            cnt_nx     = 8'd1;
            ref_p_nx   = p;
            ref_dig_nx = dig;
        end else if (state == SETTLE) begin
            cap      = cnt == 8'(STABLE_CYCLES - 1);
            cnt_nx   = cnt + 8'd1;
            state_nx = cap ? HOLD : SETTLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ref_p   <= '0;
            ref_dig <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ref_p   <= ref_p_nx;
            ref_dig <= ref_dig_nx;
        end

    // A full buffer being drained on the capture edge takes the new result instead of overflowing.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            val_q   <= '0;
            dig_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (cap && valid_q && !bus.out_ready) begin
            ovf_q <= 1'b1;
        end else if (cap) begin
            {err_q, val_q} <= dec;
            dig_q          <= dig;
            valid_q        <= 1'b1;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end

    assign bus.out_val   = val_q;
    assign bus.out_dig   = dig_q;
    assign bus.out_err   = err_q;
    assign bus.out_valid = valid_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_seg_capture_decoder.sv
// tb_seg_capture_decoder: directed and randomized checks of seg_capture_decoder
// against a run-length model of the settle/capture rules.
module tb_seg_capture_decoder;
    localparam int DIGITS = 4;
    localparam int S      = 8;
    localparam logic [7:0] CODE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'hFF, 8'h87, 8'hFD, 8'hED, 8'hE6, 8'hCF, 8'hDB, 8'h86
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_capture_decoder_if #(.DIGITS(DIGITS)) bus ();
    seg_capture_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] obs [$];
    logic [7:0] exp_q [$];
    logic       run_idle;
    int         run_len;
    logic [7:0] rp;
    int         rd;

    // Every accepted result, packed as {err, val, dig}.
    always @(negedge clk)
        if (rst_n && bus.out_valid && bus.out_ready)
            obs.push_back({bus.out_err, bus.out_val, bus.out_dig});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] p, input int d);
        logic [DIGITS-1:0] one;
        one = 1;
        bus.seg_n = ~p;
        bus.dig_n = ~(one << d);
    endtask

    function automatic logic [7:0] exp_of(input logic [7:0] p, input int d);
        exp_of = {1'b1, 4'h0, 3'(d)};
        for (int v = 0; v < 16; v++)
            if (CODE[v] == p) exp_of = {1'b0, 4'(v), 3'(d)};
    endfunction

    // A run of one non-idle (pattern, digit) lasting at least S cycles yields exactly one result.
    task automatic fin();
        if (!run_idle && run_len >= S) exp_q.push_back(exp_of(rp, rd));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_val"}, bus.out_val, 0);
        chk({tag, "_dig"}, bus.out_dig, 0);
        chk({tag, "_err"}, bus.out_err, 0);
        chk({tag, "_ovf"}, bus.overflow, 0);
    endtask

    initial begin
        bus.seg_n = '1;
        bus.dig_n = '1;
        bus.out_ready = 1'b0;
        cyc(3);
        check_zero("reset");
        rst_n = 1'b1;
        cyc(2);

        drive(8'h5B, 0);
        cyc(S + 1);
        chk("lat_early", bus.out_valid, 0);
        cyc(1);
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_val", bus.out_val, 2);
        chk("lat_dig", bus.out_dig, 0);
        chk("lat_err", bus.out_err, 0);
        bus.out_ready = 1'b1;
        cyc(1);
        chk("lat_taken", bus.out_valid, 0);
        drive(8'h00, 0);
        cyc(4);

        obs.delete();
        drive(8'h06, 0);
        cyc(5);
        drive(8'h00, 0);
        cyc(S + 6);
        chk("glitch_none", obs.size(), 0);

        bus.out_ready = 1'b0;
        drive(8'h49, 2);
        cyc(S + 4);
        chk("inv_valid", bus.out_valid, 1);
        chk("inv_err", bus.out_err, 1);
        chk("inv_val", bus.out_val, 0);
        chk("inv_dig", bus.out_dig, 2);
        bus.out_ready = 1'b1;
        cyc(1);

        obs.delete();
        bus.seg_n = ~8'h06;
        bus.dig_n = 4'b1010;
        cyc(S + 6);
        chk("two_dig", obs.size(), 0);
        drive(8'h00, 0);
        cyc(3);

        obs.delete();
        for (int v = 0; v < 16; v++) begin
            drive(CODE[v], 0);
            cyc(12);
        end
        drive(8'h00, 0);
        cyc(S + 4);
        chk("sweep_count", obs.size(), 16);
        for (int v = 0; v < 16 && v < obs.size(); v++)
            chk($sformatf("sweep_%0d", v), obs[v], {1'b0, 4'(v), 3'd0});

        bus.out_ready = 1'b0;
        drive(8'hCF, 1);
        cyc(12);
        drive(8'h6D, 2);
        cyc(12);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_val", bus.out_val, 4'hD);
        chk("bp_dig", bus.out_dig, 1);
        chk("bp_ovf", bus.overflow, 1);
        bus.out_ready = 1'b1;
        cyc(1);
        chk("bp_drained", bus.out_valid, 0);
        chk("bp_ovf_sticky", bus.overflow, 1);
        bus.out_ready = 1'b0;

        drive(8'h06, 0);
        cyc(S + 4);
        chk("rv_pre", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("rv_rst");
        #1 rst_n = 1'b1;
        cyc(S + 1);
        chk("rv_wait", bus.out_valid, 0);
        cyc(1);
        chk("rv_fresh", bus.out_valid, 1);
        chk("rv_val", bus.out_val, 1);

        drive(8'h66, 1);
        cyc(5);
        #2 rst_n = 1'b0;
        #1 check_zero("ms_rst");
        #1 rst_n = 1'b1;
        cyc(S + 1);
        chk("ms_wait", bus.out_valid, 0);
        cyc(1);
        chk("ms_valid", bus.out_valid, 1);
        chk("ms_val", bus.out_val, 4);
        chk("ms_dig", bus.out_dig, 1);

        drive(8'h4F, 3);
        cyc(S + 1);
        chk("sim_hold", bus.out_val, 4);
        bus.out_ready = 1'b1;
        cyc(1);
        chk("sim_valid", bus.out_valid, 1);
        chk("sim_val", bus.out_val, 3);
        chk("sim_dig", bus.out_dig, 3);
        chk("sim_ovf", bus.overflow, 0);
        cyc(1);
        chk("sim_drain", bus.out_valid, 0);

        drive(8'h00, 0);
        cyc(4);
        obs.delete();
        run_idle = 1'b1;
        run_len = 0;
        rp = '0;
        rd = 0;
        for (int n = 0; n < 40; n++) begin
            int r, len, a, b, d;
            logic [7:0] p;
            logic [DIGITS-1:0] dn;
            r = $urandom_range(0, 9);
            len = $urandom_range(1, S + 4);
            d = $urandom_range(0, DIGITS - 1);
            p = (r == 0) ? 8'h00 : (r < 4) ? 8'($urandom_range(1, 255)) : CODE[$urandom_range(0, 15)];
            dn = '1;
            dn[d] = 1'b0;
            if (r == 1) begin
                a = $urandom_range(0, DIGITS - 1);
                b = (a + 1 + $urandom_range(0, DIGITS - 2)) % DIGITS;
                dn = $urandom_range(0, 1) ? '1 : ~((DIGITS'(1) << a) | (DIGITS'(1) << b));
            end
            if (r == 9 && !run_idle) begin
                p = rp;
                dn = '1;
                dn[rd] = 1'b0;
                d = rd;
            end
            if (p == 8'h00 || $countones(~dn) != 1) begin
                fin();
                run_idle = 1'b1;
            end else if (run_idle || p != rp || d != rd) begin
                fin();
                run_idle = 1'b0;
                rp = p;
                rd = d;
                run_len = len;
            end else begin
                run_len += len;
            end
            bus.seg_n = ~p;
            bus.dig_n = dn;
            cyc(len);
        end
        fin();
        drive(8'h00, 0);
        cyc(S + 6);
        chk("rnd_count", obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            chk($sformatf("rnd_%0d", i), obs[i], exp_q[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
